// File: rtl/ex_pkg.sv
// +--------------------------------------------------------------------+
// | ex_pkg: shared constants and types for the bit-serial subtractor   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package ex_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  localparam int LOAD_A_BIT = 0;
  localparam int LOAD_B_BIT = 1;
  localparam int START_BIT  = 2;
  localparam int BUSY_BIT   = 7;
  localparam int DONE_BIT   = 6;
  localparam int BORROW_BIT = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'hE0;

endpackage

`default_nettype wire

// File: rtl/ex_serial_sub.sv
// +--------------------------------------------------------------------+
// | ex_serial_sub: combinational 1-bit full subtractor                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ex_serial_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

`default_nettype wire

// File: rtl/tt_um_ex_diff.sv
// +--------------------------------------------------------------------+
// | tt_um_ex_diff: Tiny Tapeout tile computing A - B bit-serially      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tt_um_ex_diff
  import ex_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  ex_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d, out_q, out_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             bw_q, bw_d, borrow_q, borrow_d, done_q, done_d;
  logic             w_d, w_bout;

  logic w_load_a, w_load_b, w_start;
  assign w_load_a = uio_in[LOAD_A_BIT];
  assign w_load_b = uio_in[LOAD_B_BIT];
  assign w_start  = uio_in[START_BIT];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

  ex_serial_sub u_sub (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .bin_i  (bw_q),
    .d_o    (w_d),
    .bout_o (w_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        // Start wins over any load strobed in the same cycle.
        if (w_start) begin
          state_d = RUN;
          sa_d    = a_q;
          sb_d    = b_q;
          cnt_d   = 3'd0;
          bw_d    = 1'b0;
          done_d  = 1'b0;
        end else begin
          if (w_load_a) a_d = ui_in;
          if (w_load_b) b_d = ui_in;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {w_d, res_q[WIDTH-1:1]};
        bw_d  = w_bout;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(WIDTH - 1)) begin
          state_d  = DONE;
          out_d    = {w_d, res_q[WIDTH-1:1]};
          borrow_d = w_bout;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    uio_out             = '0;
    uio_out[BUSY_BIT]   = (state_q == RUN);
    uio_out[DONE_BIT]   = done_q;
    uio_out[BORROW_BIT] = borrow_q;
  end

  assign uo_out = out_q;
  assign uio_oe = UIO_OE_MASK;

endmodule

`default_nettype wire

// File: doc/tt_um_ex_diff.md
# tt_um_ex_diff

Bit-serial 8-bit subtractor tile for the Tiny Tapeout harness. It is the inverse of the team's byte adder: where the adder returns `ui_in + uio_in` on `uo_out`, this block drives the `uio` pins as outputs for status. It loads operands A and B byte-wise from `ui_in` under strobes on `uio_in[2:0]`. After a start strobe it computes A − B LSB-first over 8 cycles and presents the difference on `uo_out` with busy/done/borrow flags.

## Interface
- No module parameters; `WIDTH` = 8 is a package constant fixed by the harness pin count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  always 1 when powered; ignored.
- `ui_in`  in  8  operand data byte.
- `uio_in`  in  8  bit0 `load_a`, bit1 `load_b`, bit2 `start`; bits 7:3 ignored.
- `uo_out`  out  8  last completed difference (A − B) mod 256.
- `uio_out`  out  8  bit7 `busy`, bit6 `done`, bit5 `borrow`; bits 4:0 tied 0.
- `uio_oe`  out  8  constant 8'hE0: bits 7:5 are outputs, 4:0 are inputs, including during reset.

## Operation
- Reset: with `rst_n` = 0 at a rising edge:
  - state ← IDLE; A, B, shift registers, bit counter and borrow chain ← 0.
  - `uo_out` = 0, `busy` = 0, `done` = 0, `borrow` = 0.
- FSM has three states: IDLE, RUN, DONE.
- Transitions:
  - IDLE → RUN, and DONE → RUN, when `start` = 1.
  - RUN → DONE when the bit counter = 7.
  - No other transitions.
- Loads, IDLE/DONE only:
  - `load_a` = 1: A ← `ui_in`.
  - `load_b` = 1: B ← `ui_in`.
  - Both set in the same cycle: A and B both take `ui_in`.
  - `done` is unaffected by loads.
- Start, IDLE/DONE only:
  - Copies the current A and B into the shift registers; clears the counter, borrow chain and `done`; sets `busy`.
  - Start has priority: loads asserted in the same cycle are ignored.
- RUN, one bit per cycle on a = sa[0], b = sb[0], bw = borrow chain:
  - d = a ^ b ^ bw.
  - bw' = (~a & b) | (~(a ^ b) & bw).
  - d shifts into the result register from the MSB; sa and sb shift right; counter increments.
- RUN ignores `start`, `load_a` and `load_b`. A and B are never modified by computation, so a repeated start recomputes the same result.
- Entering DONE:
  - `uo_out` ← result register, including the bit computed on this edge.
  - `borrow` ← final bw'.
  - `done` ← 1, `busy` ← 0.
- Arithmetic: unsigned; result wraps modulo 256; `borrow` = 1 iff A < B.

## Timing
- `start` sampled at edge N: `busy` = 1 from N through N+7.
- Bits 0..7 are processed at edges N+1..N+8.
- At edge N+8: `busy` = 0, `done` = 1, and `uo_out`/`borrow` are valid. Latency is 8 cycles after the start edge.
- `uo_out` and `borrow` hold the previous result throughout RUN and change only on the RUN → DONE edge.
- `done` stays high until the next accepted start.
- Back-to-back: a start in the first DONE cycle begins the next operation; `done` drops at that edge.
- Reset mid-RUN: at the next edge the operation aborts, all outputs return to reset values, and the FSM is in IDLE.

## Structure
- Shared package `ex_pkg` holds:
  - `WIDTH` = 8 and the state enum `ex_state_t` {IDLE, RUN, DONE}.
  - Pin-index constants `LOAD_A_BIT` = 0, `LOAD_B_BIT` = 1, `START_BIT` = 2, `BUSY_BIT` = 7, `DONE_BIT` = 6, `BORROW_BIT` = 5.
  - `UIO_OE_MASK` = 8'hE0.
- One sub-module, `ex_serial_sub`: a combinational 1-bit full subtractor (a, b, bin → d, bout). The top module owns the FSM, the counter and all flops.

## Test plan
- Reset check: hold `rst_n` = 0 for 2 cycles → `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hE0 throughout.
- Basic subtraction: A = 0x5A, B = 0x21, then `start` → `busy` high for exactly 8 cycles; then `uo_out` = 0x39, `borrow` = 0, `done` = 1.
- Underflow: A = 0x10, B = 0x20 → `uo_out` = 0xF0, `borrow` = 1. Also A = 0x00, B = 0x01 → 0xFF, `borrow` = 1.
- Equal and extreme operands: A = B = 0xFF → 0x00, `borrow` = 0. Then `start` again without reloading → identical result after 8 cycles.
- Ignored controls:
  - `load_a` with `ui_in` = 0x77 during RUN, and `start` during RUN → no effect; the original result completes.
  - `start` together with `load_b` in IDLE → B keeps its old value.
- Reset mid-operation: `rst_n` = 0 on RUN cycle 4 → next edge all outputs 0, FSM in IDLE. A subsequent load of 0x03/0x01 plus `start` → 0x02.
